sprite_fetch_ctrl: RTL and testbench

SPRITE_FETCH_CTRL -- requirements
Module: sprite_fetch_ctrl

---
 rtl/sprite_fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_sprite_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_ctrl.sv
// sprite_fetch_ctrl
// Walks every sprite slot during horizontal blank, fetches the ROM row of each
// slot that covers the prepared scanline and writes its opaque pixels into the
// line buffer. Slots are visited in ascending order, so higher slots win.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   line_start  one-cycle pulse that starts preparing next_line
//   next_line   scanline to prepare, captured with line_start
//   spr_en/x/y  per-slot enable, left X and top Y (held stable while busy)
//   rom_dx/dy   sprite ROM column/row address (0 outside FETCH)
//   rom_data    ROM palette index, one cycle after the address; 0 = transparent
//   lb_we/addr/data  line-buffer write port
//   busy        high while a line is in progress (including the DONE cycle)
//   done        one-cycle pulse when the line is complete
//   overrun     sticky flag: line_start arrived while busy
module sprite_fetch_ctrl #(
  parameter int NUM_SPR = 4,
  parameter int SPR_DIM = 24,
  parameter int LINE_W  = 640
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    line_start,
  input  logic [9:0]              next_line,
  input  logic [NUM_SPR-1:0]      spr_en,
  input  logic [NUM_SPR-1:0][9:0] spr_x,
  input  logic [NUM_SPR-1:0][9:0] spr_y,
  output logic [5:0]              rom_dx,
  output logic [5:0]              rom_dy,
  input  logic [7:0]              rom_data,
  output logic                    lb_we,
  output logic [9:0]              lb_addr,
  output logic [7:0]              lb_data,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int SW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, DRAIN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [9:0]      line_reg, line_next;
  logic [SW-1:0]   slot_reg, slot_next;
  logic [5:0]      dx_reg, dx_next;
  logic [5:0]      dy_reg, dy_next;
  logic            wr_pend_reg;
  logic [10:0]     wr_x_reg;
  logic            overrun_reg;

  logic [9:0]      cur_x, cur_y, diff;
  logic            cur_en, hit, last_slot;
  logic [10:0]     fetch_x;

  assign cur_x     = spr_x[slot_reg];
  assign cur_y     = spr_y[slot_reg];
  assign cur_en    = spr_en[slot_reg];
  // 10-bit wrap: sprites starting below the line produce a large difference
  // and therefore miss.
  assign diff      = line_reg - cur_y;
  assign hit       = cur_en && (diff < 10'(SPR_DIM));
  assign last_slot = (slot_reg == SW'(NUM_SPR - 1));
  // 11-bit sum so sprites hanging off the right edge are clipped, not wrapped.
  assign fetch_x   = {1'b0, cur_x} + {5'b0, dx_reg};

  always_comb begin
    state_next = state_reg;
    line_next  = line_reg;
    slot_next  = slot_reg;
    dx_next    = dx_reg;
    dy_next    = dy_reg;
    case (state_reg)
      IDLE: begin
        if (line_start) begin
          line_next  = next_line;
          slot_next  = '0;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (hit) begin
          dy_next    = diff[5:0];
          dx_next    = '0;
          state_next = FETCH;
        end else if (last_slot) begin
          state_next = DONE;
        end else begin
          slot_next  = slot_reg + SW'(1);
        end
      end
      FETCH: begin
        if (dx_reg == 6'(SPR_DIM - 1)) begin
          state_next = DRAIN;
        end else begin
          dx_next    = dx_reg + 6'd1;
        end
      end
      DRAIN: begin
        // The last column's write retires this cycle.
        if (last_slot) begin
          state_next = DONE;
        end else begin
          slot_next  = slot_reg + SW'(1);
          state_next = CHECK;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      line_reg    <= '0;
      slot_reg    <= '0;
      dx_reg      <= '0;
      dy_reg      <= '0;
      wr_pend_reg <= 1'b0;
      wr_x_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      line_reg    <= line_next;
      slot_reg    <= slot_next;
      dx_reg      <= dx_next;
      dy_reg      <= dy_next;
      // Remember the target X of the column addressed this cycle; its ROM
      // data arrives next cycle.
      wr_pend_reg <= (state_reg == FETCH);
      wr_x_reg    <= fetch_x;
      overrun_reg <= overrun_reg | (line_start && busy);
    end
  end

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign overrun = overrun_reg;
  assign rom_dx  = (state_reg == FETCH) ? dx_reg : 6'd0;
  assign rom_dy  = (state_reg == FETCH) ? dy_reg : 6'd0;
  assign lb_we   = wr_pend_reg && (rom_data != 8'd0) && (wr_x_reg < 11'(LINE_W));
  assign lb_addr = lb_we ? wr_x_reg[9:0] : 10'd0;
  assign lb_data = lb_we ? rom_data : 8'd0;

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Directed bench for sprite_fetch_ctrl. A behavioral ROM returns
// dx*8 + dy%8 + 1, or 0 (transparent) when dx%4 == 3. Expected line-buffer
// writes are queued in slot order and compared against every lb_we cycle.
// Latency convention: the cycle carrying the line_start pulse is cycle 1.
module tb_sprite_fetch_ctrl;
  localparam int NUM_SPR = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    line_start;
  logic [9:0]              next_line;
  logic [NUM_SPR-1:0]      spr_en;
  logic [NUM_SPR-1:0][9:0] spr_x;
  logic [NUM_SPR-1:0][9:0] spr_y;
  logic [5:0]              rom_dx, rom_dy;
  logic [7:0]              rom_data;
  logic                    lb_we;
  logic [9:0]              lb_addr;
  logic [7:0]              lb_data;
  logic                    busy, done, overrun;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  int          wr_cnt;
  int          first_addr, first_data, last_addr;
  int          lat;

  sprite_fetch_ctrl #(.NUM_SPR(NUM_SPR), .SPR_DIM(24), .LINE_W(640)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .next_line(next_line),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
    .rom_dx(rom_dx), .rom_dy(rom_dy), .rom_data(rom_data),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input int dx, input int dy);
    if ((dx % 4) == 3) return 8'd0;
    return 8'(dx * 8 + (dy % 8) + 1);
  endfunction

  always @(posedge clk) rom_data <= rom_f(int'(rom_dx), int'(rom_dy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line-buffer monitor: every write must match the head of the queue.
  always @(negedge clk) begin
    if (lb_we === 1'b1) begin
      if (wr_cnt == 0) begin
        first_addr = int'(lb_addr);
        first_data = int'(lb_data);
      end
      last_addr = int'(lb_addr);
      wr_cnt++;
      if (exp_q.size() == 0) check("lb_unexpected", {lb_addr, lb_data}, 32'd0);
      else check("lb_write", {lb_addr, lb_data}, exp_q.pop_front());
    end
  end

  task automatic clear_mon();
    exp_q.delete();
    wr_cnt = 0; first_addr = -1; first_data = -1; last_addr = -1;
  endtask

  task automatic build_expect(input logic [9:0] ln);
    for (int s = 0; s < NUM_SPR; s++) begin
      logic [9:0] d;
      d = ln - spr_y[s];
      if (spr_en[s] && d < 10'd24) begin
        for (int dx = 0; dx < 24; dx++) begin
          logic [7:0] px;
          px = rom_f(dx, int'(d));
          if (px != 8'd0 && (int'(spr_x[s]) + dx) < 640)
            exp_q.push_back({10'(int'(spr_x[s]) + dx), px});
        end
      end
    end
  endtask

  task automatic cfg(input int s, input logic en, input int x, input int y);
    spr_en[s] = en; spr_x[s] = 10'(x); spr_y[s] = 10'(y);
  endtask

  // Called at a negedge; pulses line_start immediately and returns the cycle
  // number on which done was seen. glitch_at > 1 re-pulses line_start then.
  task automatic run_line(input string tag, input logic [9:0] ln, input int glitch_at,
                          output int n);
    n = 1;
    next_line = ln;
    line_start = 1'b1;
    while (1) begin
      @(negedge clk);
      n++;
      line_start = (n == glitch_at);
      if (n == 2) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (done === 1'b1) break;
      if (n > 400) begin
        check({tag, "_timeout"}, 32'(done), 32'd1);
        break;
      end
    end
    line_start = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_rom0"}, {rom_dx, rom_dy}, 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_we"}, 32'(lb_we), 32'd0);
    check({tag, "_addr_data"}, {lb_addr, lb_data}, 32'd0);
    check({tag, "_rom"}, {rom_dx, rom_dy}, 32'd0);
    check({tag, "_flags"}, {busy, done, overrun}, 32'd0);
  endtask

  task automatic start_test(input logic [9:0] ln);
    clear_mon();
    build_expect(ln);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; line_start = 1'b0; next_line = '0;
    spr_en = '0; spr_x = '0; spr_y = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;

    // All slots disabled: 1 + 4 CHECK + DONE = 6.
    start_test(10'd60);
    run_line("alloff", 10'd60, 0, lat);
    check("alloff_lat", 32'(lat), 32'd6);
    check("alloff_wr", 32'(wr_cnt), 32'd0);

    // Slot 0 at (100,50), line 60: dy=10, dx%4==3 transparent -> 18 writes.
    // Latency 1 + 26 + 3 trailing misses + 1 = 31 with four slots.
    cfg(0, 1'b1, 100, 50);
    start_test(10'd60);
    run_line("single", 10'd60, 0, lat);
    check("single_lat", 32'(lat), 32'd31);
    check("single_wr", 32'(wr_cnt), 32'd18);
    check("single_first", {16'(first_addr), 16'(first_data)}, {16'd100, 16'd3});
    check("single_last", 32'(last_addr), 32'd122);

    // Bottom row boundary: line 73 -> dy=23, first pixel 0*8+7+1 = 8.
    start_test(10'd73);
    run_line("bottom", 10'd73, 0, lat);
    check("bottom_lat", 32'(lat), 32'd31);
    check("bottom_first", 32'(first_data), 32'd8);

    // Misses: line above the sprite (wrap), one past the bottom, far-Y slot.
    cfg(1, 1'b1, 300, 50);
    cfg(2, 1'b1, 400, 1000);
    start_test(10'd49);
    run_line("miss49", 10'd49, 0, lat);
    check("miss49_lat", 32'(lat), 32'd6);
    start_test(10'd74);
    run_line("miss74", 10'd74, 0, lat);
    check("miss74_lat", 32'(lat), 32'd6);
    start_test(10'd5);
    run_line("miss5", 10'd5, 0, lat);
    check("miss5_lat", 32'(lat), 32'd6);
    check("miss_wr", 32'(wr_cnt), 32'd0);

    // Right-edge clip: slot 1 at x=630 -> dx 0..9 minus dx 3,7 -> 8 writes.
    cfg(0, 1'b0, 100, 50); cfg(2, 1'b0, 400, 1000);
    cfg(1, 1'b1, 630, 50);
    start_test(10'd50);
    run_line("clip", 10'd50, 0, lat);
    check("clip_lat", 32'(lat), 32'd31);
    check("clip_wr", 32'(wr_cnt), 32'd8);
    check("clip_last", 32'(last_addr), 32'd639);

    // Slots 0 and 1 overlapping: slot 0 then slot 1, 36 writes, 1+52+2+1.
    cfg(0, 1'b1, 200, 100); cfg(1, 1'b1, 200, 100);
    start_test(10'd110);
    run_line("overlap", 10'd110, 0, lat);
    check("overlap_lat", 32'(lat), 32'd56);
    check("overlap_wr", 32'(wr_cnt), 32'd36);

    // Worst case: all four slots hit -> 4*26+2 = 106.
    cfg(0, 1'b1, 0, 10); cfg(1, 1'b1, 100, 10); cfg(2, 1'b1, 200, 10); cfg(3, 1'b1, 300, 10);
    start_test(10'd20);
    run_line("all4", 10'd20, 0, lat);
    check("all4_lat", 32'(lat), 32'd106);
    check("all4_wr", 32'(wr_cnt), 32'd72);

    // line_start mid-FETCH: ignored, overrun set and sticky.
    spr_en = '0;
    cfg(0, 1'b1, 100, 50);
    check("ovr_pre", 32'(overrun), 32'd0);
    start_test(10'd60);
    run_line("ovr", 10'd60, 10, lat);
    check("ovr_lat", 32'(lat), 32'd31);
    check("ovr_wr", 32'(wr_cnt), 32'd18);
    check("ovr_flag", 32'(overrun), 32'd1);
    @(negedge clk);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-FETCH, then a line_start in the first cycle after release.
    start_test(10'd60);
    next_line = 10'd60;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check_reset_outs("rstmid");
    repeat (2) @(negedge clk);
    check("rstmid_hold_we", 32'(lb_we), 32'd0);
    rst_n = 1'b1;
    clear_mon();
    build_expect(10'd60);
    run_line("postrst", 10'd60, 0, lat);
    check("postrst_lat", 32'(lat), 32'd31);
    check("postrst_wr", 32'(wr_cnt), 32'd18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
